// File: rtl/pal576i_sync_encoder_if.sv
// Control inputs and timing outputs of the PAL 576i composite sync encoder.
// The encoder uses the slave modport; whatever drives en/frameLock uses master.
interface pal576i_sync_encoder_if #(
    parameter int POS_W = 13
);
    logic             en;
    logic             frameLock;
    logic             csync;
    logic             hsync;
    logic             vsync;
    logic             isFieldOdd;
    logic [9:0]       lineNumber;
    logic [POS_W-1:0] linePosition;

    modport master (
        output en, frameLock,
        input  csync, hsync, vsync, isFieldOdd, lineNumber, linePosition
    );

    modport slave (
        input  en, frameLock,
        output csync, hsync, vsync, isFieldOdd, lineNumber, linePosition
    );
endinterface

// File: rtl/pal576i_sync_encoder.sv
// Free-running PAL 625-line interlaced composite sync generator (broad, equalising
// and line sync pulses) with frame-lock restart; all outputs registered one cycle after the counters.
module pal576i_sync_encoder #(
    parameter int LINE_CLKS  = 5184,
    parameter int HSYNC_CLKS = 381,
    parameter int EQ_CLKS    = 190,
    parameter int BROAD_CLKS = 2211,
    parameter int POS_W      = 13
) (
    input  logic sysClock,
    input  logic nReset,
    pal576i_sync_encoder_if.slave bus
);
    localparam logic [POS_W-1:0] LAST_P  = POS_W'(LINE_CLKS - 1);
    localparam logic [POS_W-1:0] HALF_P  = POS_W'(LINE_CLKS / 2);
    localparam logic [POS_W-1:0] HSYNC_W = POS_W'(HSYNC_CLKS);
    localparam logic [POS_W-1:0] EQ_W    = POS_W'(EQ_CLKS);
    localparam logic [POS_W-1:0] BROAD_W = POS_W'(BROAD_CLKS);

    typedef enum logic [1:0] {P_NONE, P_EQ, P_NORM, P_BROAD} pulse_e;

    // Assert immediately, release on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge sysClock or negedge nReset) begin
        if (!nReset) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [9:0]       line_q, line_d;
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        line_d = line_q;
        pos_d  = pos_q;
        if (bus.frameLock) begin
            line_d = 10'd1;
            pos_d  = '0;
        end else if (pos_q == LAST_P) begin
            pos_d  = '0;
            line_d = (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
        end else begin
            pos_d  = pos_q + 1'b1;
        end
    end

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= 10'd1;
            pos_q  <= '0;
        end else if (bus.en) begin
            line_q <= line_d;
            pos_q  <= pos_d;
        end
    end

    // Pulse type for the half-line the counters are currently in.
    logic             h1;
    pulse_e           ptype;
    logic [POS_W-1:0] width;
    logic [POS_W-1:0] offset;

    always_comb begin
        h1    = (pos_q >= HALF_P);
        ptype = P_NONE;
        if      (line_q <= 10'd2)   ptype = P_BROAD;
        else if (line_q == 10'd3)   ptype = h1 ? P_EQ : P_BROAD;
        else if (line_q <= 10'd5)   ptype = P_EQ;
        else if (line_q <= 10'd310) ptype = h1 ? P_NONE : P_NORM;
        else if (line_q <= 10'd312) ptype = P_EQ;
        else if (line_q == 10'd313) ptype = h1 ? P_BROAD : P_EQ;
        else if (line_q <= 10'd315) ptype = P_BROAD;
        else if (line_q <= 10'd317) ptype = P_EQ;
        else if (line_q == 10'd318) ptype = h1 ? P_NONE : P_EQ;
        else if (line_q <= 10'd622) ptype = h1 ? P_NONE : P_NORM;
        else if (line_q == 10'd623) ptype = h1 ? P_EQ : P_NORM;
        else                        ptype = P_EQ;

        case (ptype)
            P_EQ:    width = EQ_W;
            P_NORM:  width = HSYNC_W;
            P_BROAD: width = BROAD_W;
            default: width = '0;
        endcase
        offset = h1 ? (pos_q - HALF_P) : pos_q;
    end

    logic csync_d, hsync_d, vsync_d, field1_start, field2_start;

    assign field1_start = (line_q == 10'd1)   && (pos_q == '0);
    assign field2_start = (line_q == 10'd313) && (pos_q == HALF_P);
    assign csync_d      = !(offset < width);
    assign hsync_d      = (pos_q == '0);
    assign vsync_d      = field1_start || field2_start;

    logic             csync_q, hsync_q, vsync_q, odd_q;
    logic [9:0]       line_out_q;
    logic [POS_W-1:0] pos_out_q;

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            csync_q    <= 1'b1;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            odd_q      <= 1'b1;
            line_out_q <= 10'd1;
            pos_out_q  <= '0;
        end else if (bus.en) begin
            csync_q    <= csync_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            if (field1_start)      odd_q <= 1'b1;
            else if (field2_start) odd_q <= 1'b0;
            line_out_q <= line_q;
            pos_out_q  <= pos_q;
        end
    end

    assign bus.csync        = csync_q;
    assign bus.hsync        = hsync_q;
    assign bus.vsync        = vsync_q;
    assign bus.isFieldOdd   = odd_q;
    assign bus.lineNumber   = line_out_q;
    assign bus.linePosition = pos_out_q;
endmodule

// File: tb/tb_pal576i_sync_encoder.sv
// Directed bench for pal576i_sync_encoder using a scaled line (48 clocks) so that
// two full frames fit in a short run; pulse widths scale as 4/2/20 clocks.
module tb_pal576i_sync_encoder;
    localparam int LC = 48, HALF = 24, NW = 4, EW = 2, BW = 20, PW = 6;
    localparam int FRAME = 625 * LC;

    logic clk, rst_n;
    int   n_chk, n_bad;

    pal576i_sync_encoder_if #(.POS_W(PW)) bus ();

    pal576i_sync_encoder #(
        .LINE_CLKS(LC), .HSYNC_CLKS(NW), .EQ_CLKS(EW), .BROAD_CLKS(BW), .POS_W(PW)
    ) dut (
        .sysClock(clk),
        .nReset  (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_csync"}, 32'(bus.csync), 1);
        chk({tag, "_hsync"}, 32'(bus.hsync), 0);
        chk({tag, "_vsync"}, 32'(bus.vsync), 0);
        chk({tag, "_odd"},   32'(bus.isFieldOdd), 1);
        chk({tag, "_line"},  32'(bus.lineNumber), 1);
        chk({tag, "_pos"},   32'(bus.linePosition), 0);
    endtask

    int lo0 [1:625];
    int lo1 [1:625];

    initial begin
        int ln, ps, hs_cnt, hs_err, vs_cnt, vs_err, pos_err, fall_err, frz_err, low, waited;
        logic prev_odd, prev_cs;
        logic [31:0] snap;
        n_chk = 0; n_bad = 0;
        hs_cnt = 0; hs_err = 0; vs_cnt = 0; vs_err = 0; pos_err = 0; fall_err = 0; frz_err = 0;
        for (int i = 1; i <= 625; i++) begin lo0[i] = 0; lo1[i] = 0; end

        rst_n = 1'b0; bus.en = 1'b0; bus.frameLock = 1'b0;
        #23;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (3) step();
        chk_reset_vals("rel");
        bus.en = 1'b1;

        // Two full frames from reset: frame 1 for pulse widths, frame 2 for the odd 0->1 vsync.
        prev_odd = 1'b1; prev_cs = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            ln = (c / LC) % 625 + 1;
            ps = c % LC;
            if (bus.lineNumber != 10'(ln) || bus.linePosition != PW'(ps)) pos_err++;
            if (bus.hsync) begin
                hs_cnt++;
                if (ps != 0) hs_err++;
            end
            if (bus.vsync) begin
                vs_cnt++;
                if (!((ln == 1 && ps == 0 && bus.isFieldOdd) ||
                      (ln == 313 && ps == HALF && !bus.isFieldOdd))) vs_err++;
                if (c != 0 && prev_odd == bus.isFieldOdd) vs_err++;
            end else if (bus.isFieldOdd != prev_odd) vs_err++;
            if (!bus.csync && prev_cs && ps != 0 && ps != HALF) fall_err++;
            if (c < FRAME && !bus.csync) begin
                if (ps < HALF) lo0[ln]++;
                else           lo1[ln]++;
            end
            prev_odd = bus.isFieldOdd;
            prev_cs  = bus.csync;
        end
        chk("vsync_count", 32'(vs_cnt), 4);
        chk("vsync_place", 32'(vs_err), 0);
        chk("hsync_count", 32'(hs_cnt), 2 * 625);
        chk("hsync_place", 32'(hs_err), 0);
        chk("counter_track", 32'(pos_err), 0);
        chk("fall_at_half_start", 32'(fall_err), 0);
        chk("l100_h0", 32'(lo0[100]), NW);  chk("l100_h1", 32'(lo1[100]), 0);
        chk("l1_h0",   32'(lo0[1]),   BW);  chk("l1_h1",   32'(lo1[1]),   BW);
        chk("l2_h0",   32'(lo0[2]),   BW);  chk("l2_h1",   32'(lo1[2]),   BW);
        chk("l3_h0",   32'(lo0[3]),   BW);  chk("l3_h1",   32'(lo1[3]),   EW);
        chk("l4_h0",   32'(lo0[4]),   EW);  chk("l4_h1",   32'(lo1[4]),   EW);
        chk("l5_h0",   32'(lo0[5]),   EW);  chk("l5_h1",   32'(lo1[5]),   EW);
        chk("l313_h0", 32'(lo0[313]), EW);  chk("l313_h1", 32'(lo1[313]), BW);
        chk("l316_h0", 32'(lo0[316]), EW);  chk("l316_h1", 32'(lo1[316]), EW);
        chk("l318_h0", 32'(lo0[318]), EW);  chk("l318_h1", 32'(lo1[318]), 0);
        chk("l623_h0", 32'(lo0[623]), NW);  chk("l623_h1", 32'(lo1[623]), EW);

        // Stall 50 cycles partway into the line-1 broad pulse.
        step();
        chk("stall_start_line", 32'(bus.lineNumber), 1);
        chk("stall_start_csync", 32'(bus.csync), 0);
        low = 1;
        repeat (4) begin
            step();
            if (!bus.csync) low++;
        end
        bus.en = 1'b0;
        snap = {bus.csync, bus.hsync, bus.vsync, bus.isFieldOdd, 12'(bus.lineNumber), 16'(bus.linePosition)};
        repeat (50) begin
            step();
            if ({bus.csync, bus.hsync, bus.vsync, bus.isFieldOdd, 12'(bus.lineNumber),
                 16'(bus.linePosition)} != snap) frz_err++;
        end
        chk("stall_frozen", 32'(frz_err), 0);
        bus.en = 1'b1;
        waited = 0;
        while (waited < 100) begin
            step();
            waited++;
            if (bus.csync) break;
            low++;
        end
        chk("stall_broad_len", 32'(low), BW);

        // Frame lock at line 200 pos 30, held two cycles to cover locking at line 1 pos 0.
        waited = 0;
        while (!(bus.lineNumber == 10'd200 && bus.linePosition == PW'(29)) && waited < 20000) begin
            step();
            waited++;
        end
        chk("fl_reach", 32'(waited < 20000), 1);
        bus.frameLock = 1'b1;
        step();
        chk("fl_prev_line", 32'(bus.lineNumber), 200);
        chk("fl_prev_pos",  32'(bus.linePosition), 30);
        step();
        chk("fl_line",  32'(bus.lineNumber), 1);
        chk("fl_pos",   32'(bus.linePosition), 0);
        chk("fl_vsync", 32'(bus.vsync), 1);
        chk("fl_hsync", 32'(bus.hsync), 1);
        chk("fl_csync", 32'(bus.csync), 0);
        chk("fl_odd",   32'(bus.isFieldOdd), 1);
        bus.frameLock = 1'b0;
        step();
        chk("fl_rep_pos",   32'(bus.linePosition), 0);
        chk("fl_rep_vsync", 32'(bus.vsync), 1);
        step();
        chk("fl_adv_pos",   32'(bus.linePosition), 1);
        chk("fl_adv_vsync", 32'(bus.vsync), 0);

        // frameLock ignored while disabled.
        bus.en = 1'b0; bus.frameLock = 1'b1;
        step();
        chk("fl_dis_pos", 32'(bus.linePosition), 1);
        bus.en = 1'b1; bus.frameLock = 1'b0;
        step();
        chk("fl_dis_next", 32'(bus.linePosition), 2);

        // Asynchronous reset mid-broad on line 2.
        repeat (50) step();
        chk("pre_rst_line",  32'(bus.lineNumber), 2);
        chk("pre_rst_csync", 32'(bus.csync), 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        #10;
        bus.en = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        bus.en = 1'b1;
        step();
        chk("restart_line",  32'(bus.lineNumber), 1);
        chk("restart_pos",   32'(bus.linePosition), 0);
        chk("restart_hsync", 32'(bus.hsync), 1);
        chk("restart_vsync", 32'(bus.vsync), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
